// File: rtl/timing_multi_pkg.sv
// Shared definitions for the timing_multi timer block.
// Build option: TIMING_STICKY_INT_EN makes channel interrupts sticky until cleared.
`ifndef TIMING_CH_SLICE
`define TIMING_CH_SLICE(i, w) ((i)*(w)) +: (w)
`endif

package timing_multi_pkg;

    localparam logic TIMING_MODE_ONESHOT = 1'b0;
    localparam logic TIMING_MODE_CONT    = 1'b1;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } ch_state_e;

endpackage

// File: rtl/timing_multi_channel.sv
// One count-up timer channel: run state, counter and interrupt register.
// Build option: TIMING_STICKY_INT_EN adds int_clr and makes intr sticky.
//
// state   | meaning
// CH_IDLE | stopped, count holds
// CH_RUN  | counting toward termcount, hit raises intr
module timing_channel
    import timing_multi_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         trig_start,
    input  logic         trig_halt,
    input  logic         mode,
    input  logic [W-1:0] termcount,
`ifdef TIMING_STICKY_INT_EN
    input  logic         int_clr,
`endif
    output logic         status,
    output logic [W-1:0] currcount,
    output logic         intr
);

    ch_state_e    state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic         int_q, int_d;
    logic         hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= CH_IDLE;
            count_q <= '0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            int_q   <= int_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hit     = 1'b0;
        if (trig_halt) begin
            state_d = CH_IDLE;
            count_d = '0;
        end else if (trig_start) begin
            state_d = CH_RUN;
            count_d = '0;
        end else if (state_q == CH_RUN) begin
            if (count_q == termcount) begin
                hit     = 1'b1;
                count_d = '0;
                if (mode == TIMING_MODE_ONESHOT) begin
                    state_d = CH_IDLE;
                end
            end else begin
                count_d = count_q + W'(1);
            end
        end
    end

    // A set always wins over a coincident clear; halt leaves a pending flag alone.
`ifdef TIMING_STICKY_INT_EN
    assign int_d = hit | (int_q & ~int_clr);
`else
    assign int_d = hit;
`endif

    assign status    = (state_q == CH_RUN);
    assign currcount = count_q;
    assign intr      = int_q;

endmodule

// File: rtl/timing_multi.sv
// NUM_CH independent W-bit count-up timers with a combined interrupt request.
// Build option: TIMING_STICKY_INT_EN adds ro_int_clr and sticky per-channel interrupts.
module timing_multi
    import timing_multi_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int W      = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   ro_trig_start,
    input  logic [NUM_CH-1:0]   ro_trig_halt,
    input  logic [NUM_CH-1:0]   ro_mode,
    input  logic [NUM_CH*W-1:0] ro_termcount,
`ifdef TIMING_STICKY_INT_EN
    input  logic [NUM_CH-1:0]   ro_int_clr,
`endif
    output logic [NUM_CH-1:0]   rf_status,
    output logic [NUM_CH*W-1:0] rf_currcount,
    output logic [NUM_CH-1:0]   rf_int,
    output logic                rf_irq
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timing_channel #(
            .W (W)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .trig_start (ro_trig_start[i]),
            .trig_halt  (ro_trig_halt[i]),
            .mode       (ro_mode[i]),
            .termcount  (ro_termcount[`TIMING_CH_SLICE(i, W)]),
`ifdef TIMING_STICKY_INT_EN
            .int_clr    (ro_int_clr[i]),
`endif
            .status     (rf_status[i]),
            .currcount  (rf_currcount[`TIMING_CH_SLICE(i, W)]),
            .intr       (rf_int[i])
        );
    end

    // Interrupt bits are already registered, so the OR adds no cycle of latency.
    assign rf_irq = |rf_int;

endmodule

// File: tb/tb_timing_multi.sv
// Scoreboard bench for timing_multi (NUM_CH=4, W=4); sticky checks with TIMING_STICKY_INT_EN.
`timescale 1ns/100ps
module tb_timing_multi;

    localparam int NCH = 4;
    localparam int CW  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    ro_trig_start, ro_trig_halt, ro_mode;
    logic [NCH*CW-1:0] ro_termcount;
`ifdef TIMING_STICKY_INT_EN
    logic [NCH-1:0]    ro_int_clr;
`endif
    logic [NCH-1:0]    rf_status, rf_int;
    logic [NCH*CW-1:0] rf_currcount;
    logic              rf_irq;

    timing_multi #(.NUM_CH(NCH), .W(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ro_trig_start (ro_trig_start),
        .ro_trig_halt  (ro_trig_halt),
        .ro_mode       (ro_mode),
        .ro_termcount  (ro_termcount),
`ifdef TIMING_STICKY_INT_EN
        .ro_int_clr    (ro_int_clr),
`endif
        .rf_status     (rf_status),
        .rf_currcount  (rf_currcount),
        .rf_int        (rf_int),
        .rf_irq        (rf_irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    st;
        logic [NCH*CW-1:0] cnt;
        logic [NCH-1:0]    intr;
        logic              irq;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    logic        m_st [NCH];
    logic [CW-1:0] m_cnt [NCH];
    logic        m_int [NCH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_st[i]  = 1'b0;
            m_cnt[i] = '0;
            m_int[i] = 1'b0;
        end
        sb.delete();
    endtask

    // Reference behaviour for the coming edge, using the inputs as they stand now.
    task automatic model_tick();
        exp_t e;
        for (int i = 0; i < NCH; i++) begin
            logic [CW-1:0] term;
            logic          hit;
            term = ro_termcount[i*CW +: CW];
            hit  = 1'b0;
            if (ro_trig_halt[i]) begin
                m_st[i] = 1'b0; m_cnt[i] = '0;
            end else if (ro_trig_start[i]) begin
                m_st[i] = 1'b1; m_cnt[i] = '0;
            end else if (m_st[i]) begin
                if (m_cnt[i] == term) begin
                    hit = 1'b1;
                    m_cnt[i] = '0;
                    if (!ro_mode[i]) m_st[i] = 1'b0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1'b1;
                end
            end
`ifdef TIMING_STICKY_INT_EN
            m_int[i] = hit | (m_int[i] & ~ro_int_clr[i]);
`else
            m_int[i] = hit;
`endif
            e.st[i]             = m_st[i];
            e.cnt[i*CW +: CW]   = m_cnt[i];
            e.intr[i]           = m_int[i];
        end
        e.irq = |e.intr;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_tick();
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sb_status", rf_status, e.st);
            check("sb_count", rf_currcount, e.cnt);
            check("sb_int", rf_int, e.intr);
            check("sb_irq", rf_irq, e.irq);
        end
        ro_trig_start = '0;
        ro_trig_halt  = '0;
`ifdef TIMING_STICKY_INT_EN
        ro_int_clr    = '0;
`endif
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset         = 1'b1;
        ro_trig_start = '0;
        ro_trig_halt  = '0;
        ro_mode       = '0;
        ro_termcount  = '0;
`ifdef TIMING_STICKY_INT_EN
        ro_int_clr    = '0;
`endif
        model_reset();
        #1;
        check("reset_status", rf_status, 0);
        check("reset_count", rf_currcount, 0);
        check("reset_int", rf_int, 0);
        check("reset_irq", rf_irq, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Asynchronous reset in the middle of a run
        ro_mode[0] = 1'b1; ro_termcount[3:0] = 4'd15; ro_trig_start[0] = 1'b1;
        step();
        run(5);
        check("rst_pre_count", rf_currcount[3:0], 5);
        #2 reset = 1'b1;
        #1;
        check("rst_async_status", rf_status, 0);
        check("rst_async_count", rf_currcount, 0);
        check("rst_async_irq", rf_irq, 0);
        #2 reset = 1'b0;
        model_reset();
        run(4);
        check("rst_stays_idle", rf_status[0], 0);
        check("rst_count_held", rf_currcount[3:0], 0);

        // One-shot, term=3
        ro_mode[0] = 1'b0; ro_termcount[3:0] = 4'd3; ro_trig_start[0] = 1'b1;
        step();
        check("os_start_count", rf_currcount[3:0], 0);
        check("os_start_status", rf_status[0], 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("os_count", rf_currcount[3:0], k);
            check("os_no_int", rf_int[0], 0);
        end
        step();
        check("os_hit_int", rf_int[0], 1);
        check("os_hit_status", rf_status[0], 0);
        check("os_hit_count", rf_currcount[3:0], 0);
        step();
`ifndef TIMING_STICKY_INT_EN
        check("os_int_pulse", rf_int[0], 0);
`endif
        run(5);
        check("os_still_idle", rf_status[0], 0);

        // Continuous, term=2 on ch1
        ro_mode[1] = 1'b1; ro_termcount[7:4] = 4'd2; ro_trig_start[1] = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            check("cont_count", rf_currcount[7:4], k % 3);
            check("cont_status", rf_status[1], 1);
`ifndef TIMING_STICKY_INT_EN
            check("cont_int", rf_int[1], (k % 3) == 0);
`endif
        end
        ro_trig_halt[1] = 1'b1;
        step();

        // Priority: halt beats start; start restarts a running channel
        ro_trig_start[0] = 1'b1; ro_trig_halt[0] = 1'b1;
        step();
        check("prio_status", rf_status[0], 0);
        check("prio_count", rf_currcount[3:0], 0);
        ro_mode[0] = 1'b1; ro_termcount[3:0] = 4'd15; ro_trig_start[0] = 1'b1;
        step();
        run(7);
        check("restart_pre", rf_currcount[3:0], 7);
        ro_trig_start[0] = 1'b1;
        step();
        check("restart_count", rf_currcount[3:0], 0);
        check("restart_status", rf_status[0], 1);
        ro_trig_halt[0] = 1'b1;
        step();

        // Independent channels: ch2 continuous term=1, ch3 one-shot term=15
        ro_mode[2] = 1'b1; ro_termcount[11:8]  = 4'd1;
        ro_mode[3] = 1'b0; ro_termcount[15:12] = 4'd15;
        ro_trig_start[2] = 1'b1; ro_trig_start[3] = 1'b1;
        step();
        run(15);
        check("indep_ch3_count", rf_currcount[15:12], 15);
        step();
        check("indep_ch3_done", rf_status[3], 0);
        check("indep_ch2_run", rf_status[2], 1);
        run(4);

        // Term lowered below the count: wrap through 15 -> 0 before the hit
        ro_mode[0] = 1'b1; ro_termcount[3:0] = 4'd10; ro_trig_start[0] = 1'b1;
        step();
        run(8);
        check("wrap_pre", rf_currcount[3:0], 8);
        ro_termcount[3:0] = 4'd3;
        run(7);
        check("wrap_top", rf_currcount[3:0], 15);
        step();
        check("wrap_zero", rf_currcount[3:0], 0);
        check("wrap_no_int", rf_int[0], 0);
        run(3);
        check("wrap_at_term", rf_currcount[3:0], 3);
        step();
        check("wrap_hit", rf_int[0], 1);

`ifdef TIMING_STICKY_INT_EN
        // Sticky interrupt: hold until clear, set wins over clear, halt keeps it
        ro_trig_halt = '1;
        step();
        ro_int_clr = '1;
        step();
        check("sticky_cleared", rf_int, 0);
        ro_mode[0] = 1'b1; ro_termcount[3:0] = 4'd2; ro_trig_start[0] = 1'b1;
        step();
        run(3);
        check("sticky_set", rf_int[0], 1);
        run(2);
        check("sticky_hold", rf_int[0], 1);
        ro_int_clr[0] = 1'b1;
        step();
        check("sticky_set_over_clr", rf_int[0], 1);
        ro_int_clr[0] = 1'b1;
        step();
        check("sticky_clr", rf_int[0], 0);
        run(2);
        check("sticky_reset_again", rf_int[0], 1);
        ro_trig_halt[0] = 1'b1;
        step();
        check("sticky_halt_keeps", rf_int[0], 1);
        check("sticky_halt_status", rf_status[0], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
